// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Drives icache requests from the PC and buffers icache hits in a
// small circular queue so that fetching continues while decode stalls.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   iREN, imemaddr        icache request and address (current PC)
//   ihit, imemload        icache hit flag and returned word
//   stall                 hold the queue head (IF/ID stall)
//   redirect, redirect_pc flush the queue and load a new PC
//   halt                  stop fetching; left only by reset
//   valid_out, instr_out  queue head to IF/ID (nop when empty)
//   pc_4_out              PC+4 of the head instruction
//   halted, fetch_count   halted flag, instructions popped since reset
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          DEPTH   = 2
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc_4_out,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic {
      S_FETCH,
      S_HALTED
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_fetching;
   logic            w_halt_go;

   logic [31:0]     r_pc;
   logic [31:0]     r_fetch_count;
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic [31:0]     r_instr [DEPTH];
   logic [31:0]     r_pc4   [DEPTH];

   logic            w_ren;
   logic            w_push;
   logic            w_valid;
   logic            w_pop;
   logic [31:0]     w_pc_4;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Redirect outranks halt: a halt seen alongside a redirect
   // belongs to a wrong-path instruction.
   always_comb begin
      w_state_nxt = r_state;
      w_fetching  = 1'b0;
      w_halt_go   = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            w_fetching = 1'b1;
            if (halt && !redirect) begin
               w_state_nxt = S_HALTED;
               w_halt_go   = 1'b1;
            end
         end
         S_HALTED: begin
            w_state_nxt = S_HALTED;
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

   assign w_pc_4  = r_pc + 32'd4;
   assign w_ren   = w_fetching && (r_count < CW'(DEPTH)) && !redirect;
   assign w_push  = w_ren && ihit;
   assign w_valid = (r_count != '0) && w_fetching;
   // A redirect flushes IF/ID, so the head is not consumed that cycle.
   assign w_pop   = w_valid && !stall && !redirect;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc          <= PC_INIT;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_fetch_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_instr[i] <= '0;
            r_pc4[i]   <= '0;
         end
      end else if (redirect) begin
         r_pc    <= redirect_pc & ~32'h3;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_instr[r_tail] <= imemload;
            r_pc4[r_tail]   <= w_pc_4;
            r_tail          <= r_tail + AW'(1);
            r_pc            <= w_pc_4;
         end
         if (w_pop) begin
            r_head        <= r_head + AW'(1);
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         // Halting drops everything behind the halt instruction.
         if (w_halt_go) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign iREN        = w_ren;
   assign imemaddr    = r_pc;
   assign valid_out   = w_valid;
   assign instr_out   = w_valid ? r_instr[r_head] : 32'd0;
   assign pc_4_out    = w_valid ? r_pc4[r_head] : 32'd0;
   assign halted      = (r_state == S_HALTED);
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random stimulus against a queue-based reference model.
// PC_INIT sits at the top of the address space to exercise PC wrap.
module tb_fetch_unit;

   localparam logic [31:0] PC_INIT = 32'hFFFF_FFFC;
   localparam int          DEPTH   = 2;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc_4_out;
   logic        halted;
   logic [31:0] fetch_count;

   fetch_unit #(
      .PC_INIT(PC_INIT),
      .DEPTH  (DEPTH)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .iREN       (iREN),
      .imemaddr   (imemaddr),
      .ihit       (ihit),
      .imemload   (imemload),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .halt       (halt),
      .valid_out  (valid_out),
      .instr_out  (instr_out),
      .pc_4_out   (pc_4_out),
      .halted     (halted),
      .fetch_count(fetch_count)
   );

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc4;
   } ent_t;

   // Reference model: fetched words awaiting decode, in order.
   ent_t        exp_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_fc;
   bit          m_halted;
   bit          m_known;
   bit          m_ren;
   bit          m_valid;

   int n_chk;
   int n_pass;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Monitor: compares DUT outputs with the model and consumes the
   // expected head whenever decode takes it.
   initial begin
      forever begin
         @(negedge CLK);
         #2;
         if (m_known) begin
            m_ren   = !m_halted && (exp_q.size() < DEPTH) && !redirect;
            m_valid = !m_halted && (exp_q.size() != 0);
            chk("iREN", 32'(iREN), 32'(m_ren));
            chk("halted", 32'(halted), 32'(m_halted));
            if (!m_halted) chk("imemaddr", imemaddr, m_pc);
            chk("valid_out", 32'(valid_out), 32'(m_valid));
            chk("fetch_count", fetch_count, m_fc);
            if (m_valid) begin
               chk("instr_out", instr_out, exp_q[0].ins);
               chk("pc_4_out", pc_4_out, exp_q[0].pc4);
            end else begin
               chk("instr_out_nop", instr_out, 32'd0);
               chk("pc_4_out_nop", pc_4_out, 32'd0);
            end
            if (m_valid && !stall && !redirect && !RST) begin
               void'(exp_q.pop_front());
               m_fc = m_fc + 32'd1;
            end
         end
      end
   end

   // Model state update at each clock edge.
   initial begin
      m_known  = 1'b0;
      m_halted = 1'b0;
      m_pc     = PC_INIT;
      m_fc     = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (RST) begin
            m_known  = 1'b1;
            m_pc     = PC_INIT;
            m_halted = 1'b0;
            m_fc     = '0;
            exp_q.delete();
         end else if (m_known) begin
            if (redirect) begin
               exp_q.delete();
               m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
               if (m_ren && ihit) begin
                  exp_q.push_back(ent_t'{ins: imemload, pc4: m_pc + 32'd4});
                  m_pc = m_pc + 32'd4;
               end
               if (halt && !m_halted) begin
                  m_halted = 1'b1;
                  exp_q.delete();
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      int mode;
      n_chk       = 0;
      n_pass      = 0;
      mode        = 0;
      RST         = 1'b1;
      ihit        = 1'b0;
      imemload    = '0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      halt        = 1'b0;
      repeat (3) @(negedge CLK);
      RST  = 1'b0;
      ihit = 1'b1;
      imemload = 32'h1234_0000;
      repeat (6) @(negedge CLK);
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLK);
         if (c % 100 == 0) mode = int'($urandom_range(0, 2));
         case (mode)
            0:       stall = 1'b0;
            1:       stall = ($urandom_range(0, 2) == 0);
            default: stall = ($urandom_range(0, 3) != 0);
         endcase
         ihit     = ($urandom_range(0, 3) != 0);
         imemload = $urandom;
         redirect = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 1) == 0) begin
            redirect_pc = {24'd0, 8'($urandom)};
         end else begin
            redirect_pc = $urandom;
         end
         halt = !m_halted && (exp_q.size() != 0) &&
                ($urandom_range(0, 39) == 0);
         if (m_halted) begin
            RST = ($urandom_range(0, 5) == 0);
         end else begin
            RST = ($urandom_range(0, 299) == 0);
         end
      end
      @(negedge CLK);
      #5;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that drives the icache request and feeds the IF/ID pipeline register. It holds the PC and a small instruction queue that absorbs icache hits while decode is stalled. It accepts redirects (branch, jump, JR, flush) from the later stages and stops fetching on halt. Its outputs connect directly to the IF/ID inputs (instr_in_1, pc_4_in_1).

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, instruction queue entries (power of two, ≥2)

Ports:
CLK  in  1  clock; all state changes on the rising edge
RST  in  1  synchronous reset, active-high
iREN  out  1  icache read request
imemaddr  out  32  icache address; always equals the current PC
ihit  in  1  icache hit; imemload is valid in the same cycle
imemload  in  32  instruction word returned by the icache
stall  in  1  IF/ID hold request from the hazard unit or an outstanding dhit
redirect  in  1  flush plus new PC, taken from EX/MEM branch/jump resolution
redirect_pc  in  32  redirect target address
halt  in  1  decode has seen a halt opcode at the queue head
valid_out  out  1  queue head is valid
instr_out  out  32  head instruction; 0 (nop) when the queue is empty
pc_4_out  out  32  PC+4 of the head instruction; 0 when the queue is empty
halted  out  1  the unit is in the HALTED state
fetch_count  out  32  number of instructions popped into IF/ID since reset

Behaviour:
- Reset (synchronous, RST=1 at the edge):
  - pc=PC_INIT, queue count=0, head and tail pointers=0, state=FETCH, fetch_count=0.
  - Resulting outputs: iREN=1, valid_out=0, instr_out=0, pc_4_out=0, halted=0.
- States:
  - FETCH: normal operation.
  - HALTED: fetching stopped. Left only by reset.
- Request:
  - iREN = (state==FETCH) && (count<DEPTH) && !redirect.
  - imemaddr = pc (combinational from the register).
- Push: when iREN && ihit, write {imemload, pc+4} at tail, advance tail, pc <= pc+4.
  - pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- Pop: when valid_out && !stall, advance head and increment fetch_count (wraps mod 2^32).
  - valid_out = (count!=0) && (state==FETCH).
  - Head entry is presented combinationally.
- Simultaneous push and pop: count is unchanged.
  - With count==DEPTH, iREN is 0, so no push occurs that cycle even if a pop happens. A push resumes the next cycle.
- Fetch latency: instruction at address A reaches instr_out in the cycle after its ihit, provided the queue was empty.
- Redirect (priority below reset, above everything else):
  - Queue cleared (count=0, pointers=0).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Any ihit in the same cycle is discarded.
  - No pop is counted that cycle.
  - valid_out stays as computed that cycle, but IF/ID is flushed by the same signal.
- Halt: when halt && !redirect && state==FETCH:
  - Next state HALTED; queue cleared.
  - The halt instruction itself is popped and counted, unless stall is high that cycle.
  - In HALTED: iREN=0, valid_out=0, instr_out=0, pc frozen, halted=1.
- halt and redirect in the same cycle: redirect wins; the halt came from a wrong-path instruction.
- stall while the queue is non-empty: the head is held stable; pushes continue until full.
- Reset mid-operation: takes effect at the next edge regardless of state, ihit or queue contents.
- RTL constraints:
  - No latches.
  - All queue storage and the pc live in one clocked block with synchronous reset.

Test Plan:
- Reset then ihit held at 1, stall=0, imemload=addr-derived values:
  - instr_out sequence matches words at 0x0, 0x4, 0x8, …
  - pc_4_out = 0x4, 0x8, 0xC; fetch_count increments each cycle.
- stall=1 for 4 cycles with ihit=1:
  - Queue fills to 2, then iREN=0.
  - instr_out holds the word for 0x0 throughout.
  - After release, 0x0, 0x4, 0x8 come out in order with none lost or duplicated.
- redirect=1, redirect_pc=0x0000_0103, with ihit=1 and a full queue:
  - Next cycle imemaddr=0x100, valid_out=0.
  - The discarded hit does not appear at instr_out.
- halt=1 at head with stall=0:
  - halted=1 next cycle, iREN=0, valid_out=0.
  - fetch_count includes the halt; further ihit pulses are ignored until RST.
- halt=1 and redirect=1 in the same cycle (redirect_pc=0x40):
  - halted stays 0 and imemaddr=0x40.
  - Then RST=1 mid-fetch: imemaddr=PC_INIT, count=0, fetch_count=0.
- PC_INIT=32'hFFFF_FFFC with ihit=1: imemaddr goes to 0x0 next; pc_4_out of the first instruction is 0x0.
